// File: rtl/g_macro_pkg.sv
// Shared constants and types for the registered mixed-polarity NOR macro family.
package g_macro_pkg;

  localparam int N_MAX  = 16;
  localparam int CH_MAX = 32;

  // Counter width able to hold FILT-1 with headroom for the compare.
  function automatic int filt_w(input int filt);
    return $clog2(filt + 1);
  endfunction

  // Widest counter any legal FILT (1..255) needs.
  localparam int CNT_W_MAX = 8;

  typedef struct packed {
    logic                 yn;
    logic [CNT_W_MAX-1:0] cnt;
  } flt_state_t;

endpackage

// File: rtl/g_nor_flt_ch.sv
// One channel: masked N-input NOR, persistence filter, registered YN and change pulse.
module g_nor_flt_ch
  import g_macro_pkg::*;
#(
  parameter int   N      = 4,
  parameter int   FILT   = 1,
  parameter logic YN_RST = 1'b0
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         ce,
  input  logic         clr,
  input  logic [N-1:0] d,
  input  logic [N-1:0] mask,
  output logic         yn,
  output logic         chg
);

  localparam logic [CNT_W_MAX-1:0] CNT_LAST = CNT_W_MAX'(FILT - 1);

  flt_state_t st_reg;
  flt_state_t st_next;
  logic       chg_reg;
  logic       chg_next;
  logic       raw;

  assign raw = ~|(d ^ mask);

  always_comb begin
    st_next  = st_reg;
    chg_next = 1'b0;
    if (clr) begin
      // A mask load restarts every partial count but leaves YN alone.
      st_next.cnt = '0;
    end else if (ce) begin
      if (raw == st_reg.yn) begin
        st_next.cnt = '0;
      end else if (st_reg.cnt == CNT_LAST) begin
        st_next.yn  = raw;
        st_next.cnt = '0;
        chg_next    = 1'b1;
      end else begin
        st_next.cnt = st_reg.cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      st_reg.yn  <= YN_RST;
      st_reg.cnt <= '0;
      chg_reg    <= 1'b0;
    end else begin
      st_reg  <= st_next;
      chg_reg <= chg_next;
    end
  end

  assign yn  = st_reg.yn;
  assign chg = chg_reg;

endmodule

// File: rtl/g_nnor_flt.sv
// CH-channel registered, deglitched mixed-polarity NOR decode.
// Define G_NNOR_RT_MASK_EN to add a run-time loadable inversion mask (MASK_LD/MASK_IN).
module g_nnor_flt
  import g_macro_pkg::*;
#(
  parameter int           N        = 4,
  parameter int           CH       = 1,
  parameter logic [N-1:0] INV_MASK = 4'b0111,
  parameter int           FILT     = 1,
  parameter logic         YN_RST   = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic [CH*N-1:0] D,
`ifdef G_NNOR_RT_MASK_EN
  input  logic          MASK_LD,
  input  logic [N-1:0]  MASK_IN,
`endif
  output logic [CH-1:0] YN,
  output logic [CH-1:0] CHG
);

  logic [N-1:0] mask;
  logic         mask_ld;

`ifdef G_NNOR_RT_MASK_EN
  logic [N-1:0] mask_reg;

  // Load is honoured regardless of CE; only reset takes priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask_reg <= INV_MASK;
    end else if (MASK_LD) begin
      mask_reg <= MASK_IN;
    end
  end

  assign mask    = mask_reg;
  assign mask_ld = MASK_LD;
`else
  assign mask    = INV_MASK;
  assign mask_ld = 1'b0;
`endif

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    g_nor_flt_ch #(
      .N      (N),
      .FILT   (FILT),
      .YN_RST (YN_RST)
    ) u_ch (
      .clk  (CLK),
      .srst (RST),
      .ce   (CE),
      .clr  (mask_ld),
      .d    (D[gi*N +: N]),
      .mask (mask),
      .yn   (YN[gi]),
      .chg  (CHG[gi])
    );
  end

endmodule

// File: tb/tb_g_nnor_flt.sv
// Directed bench for g_nnor_flt: several parameterisations sharing one clock/reset/CE.
module tb_g_nnor_flt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ce  = 1'b1;
  logic mask_ld = 1'b0;
  logic [3:0] mask_in = 4'b0000;

  logic [3:0]  d_f1 = '0, d_f4 = '0, d_f3 = '0;
  logic [11:0] d_ch = '0;
  logic yn_f1, chg_f1, yn_f4, chg_f4, yn_f3, chg_f3;
  logic [2:0] yn_ch, chg_ch;

  int checks = 0;
  int errors = 0;

  g_nnor_flt #(.N(4), .CH(1), .INV_MASK(4'b0111), .FILT(1), .YN_RST(1'b0)) u_f1 (
    .CLK(clk), .RST(rst), .CE(ce), .D(d_f1),
`ifdef G_NNOR_RT_MASK_EN
    .MASK_LD(mask_ld), .MASK_IN(mask_in),
`endif
    .YN(yn_f1), .CHG(chg_f1));

  g_nnor_flt #(.N(4), .CH(1), .INV_MASK(4'b0111), .FILT(4), .YN_RST(1'b0)) u_f4 (
    .CLK(clk), .RST(rst), .CE(ce), .D(d_f4),
`ifdef G_NNOR_RT_MASK_EN
    .MASK_LD(mask_ld), .MASK_IN(mask_in),
`endif
    .YN(yn_f4), .CHG(chg_f4));

  g_nnor_flt #(.N(4), .CH(1), .INV_MASK(4'b0111), .FILT(3), .YN_RST(1'b0)) u_f3 (
    .CLK(clk), .RST(rst), .CE(ce), .D(d_f3),
`ifdef G_NNOR_RT_MASK_EN
    .MASK_LD(mask_ld), .MASK_IN(mask_in),
`endif
    .YN(yn_f3), .CHG(chg_f3));

  g_nnor_flt #(.N(4), .CH(3), .INV_MASK(4'b0111), .FILT(2), .YN_RST(1'b0)) u_ch (
    .CLK(clk), .RST(rst), .CE(ce), .D(d_ch),
`ifdef G_NNOR_RT_MASK_EN
    .MASK_LD(mask_ld), .MASK_IN(mask_in),
`endif
    .YN(yn_ch), .CHG(chg_ch));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({yn_f1, chg_f1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_f1: yn/chg=%b%b expected 00", yn_f1, chg_f1);
    end
    checks++;
    if ({yn_ch, chg_ch} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_ch: yn=%b chg=%b expected 000 000", yn_ch, chg_ch);
    end
    $display("reset: yn_f1=%b yn_ch=%b", yn_f1, yn_ch);
  endtask

  task automatic test_filt1;
    d_f1 = 4'b0111;
    tick();
    checks++;
    if ({yn_f1, chg_f1} !== 2'b11) begin
      errors++;
      $display("FAIL filt1_rise: yn/chg=%b%b expected 11", yn_f1, chg_f1);
    end
    tick();
    checks++;
    if ({yn_f1, chg_f1} !== 2'b10) begin
      errors++;
      $display("FAIL filt1_hold: yn/chg=%b%b expected 10", yn_f1, chg_f1);
    end
    d_f1 = 4'b1111;
    tick();
    checks++;
    if ({yn_f1, chg_f1} !== 2'b01) begin
      errors++;
      $display("FAIL filt1_fall: yn/chg=%b%b expected 01", yn_f1, chg_f1);
    end
    $display("filt1: yn=%b chg=%b", yn_f1, chg_f1);
  endtask

  task automatic test_glitch;
    d_f4 = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({yn_f4, chg_f4} !== 2'b00) begin
        errors++;
        $display("FAIL glitch_short%0d: yn/chg=%b%b expected 00", i, yn_f4, chg_f4);
      end
    end
    d_f4 = 4'b0000;
    tick();
    checks++;
    if ({yn_f4, chg_f4} !== 2'b00) begin
      errors++;
      $display("FAIL glitch_revert: yn/chg=%b%b expected 00", yn_f4, chg_f4);
    end
    d_f4 = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({yn_f4, chg_f4} !== ((i == 3) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL glitch_full%0d: yn/chg=%b%b expected %b", i, yn_f4, chg_f4,
                 (i == 3) ? 2'b11 : 2'b00);
      end
    end
    tick();
    checks++;
    if ({yn_f4, chg_f4} !== 2'b10) begin
      errors++;
      $display("FAIL glitch_pulse_end: yn/chg=%b%b expected 10", yn_f4, chg_f4);
    end
    $display("glitch: yn=%b chg=%b", yn_f4, chg_f4);
  endtask

  task automatic test_ce_gaps;
    logic [6:0] ce_seq;
    ce_seq = 7'b1010101;
    d_f4 = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      ce = ce_seq[6-i];
      tick();
      checks++;
      if ({yn_f4, chg_f4} !== ((i == 6) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL ce_gap%0d: yn/chg=%b%b expected %b", i, yn_f4, chg_f4,
                 (i == 6) ? 2'b01 : 2'b10);
      end
    end
    ce = 1'b1;
    $display("ce_gaps: yn=%b chg=%b", yn_f4, chg_f4);
  endtask

  task automatic test_rst_mid;
    d_f3 = 4'b0111;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({yn_f3, chg_f3} !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre: yn/chg=%b%b expected 11", yn_f3, chg_f3);
    end
    d_f3 = 4'b0000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({yn_f3, chg_f3} !== 2'b00) begin
      errors++;
      $display("FAIL rst_to_ynrst: yn/chg=%b%b expected 00", yn_f3, chg_f3);
    end
    d_f3 = 4'b0111;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({yn_f3, chg_f3} !== ((i == 2) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL rst_restart%0d: yn/chg=%b%b expected %b", i, yn_f3, chg_f3,
                 (i == 2) ? 2'b11 : 2'b00);
      end
    end
    $display("rst_mid: yn=%b chg=%b", yn_f3, chg_f3);
  endtask

  task automatic test_channels;
    logic [2:0] exp_yn [6];
    logic [2:0] exp_chg [6];
    exp_yn  = '{3'b000, 3'b010, 3'b111, 3'b111, 3'b111, 3'b101};
    exp_chg = '{3'b000, 3'b010, 3'b101, 3'b000, 3'b000, 3'b010};
    d_ch = 12'b0000_0111_0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) d_ch = 12'b0111_0111_0111;
      if (i == 3) d_ch = 12'b0111_0000_0111;
      checks++;
      if ({yn_ch, chg_ch} !== {exp_yn[i], exp_chg[i]}) begin
        errors++;
        $display("FAIL channels%0d: yn=%b chg=%b expected %b %b", i, yn_ch, chg_ch,
                 exp_yn[i], exp_chg[i]);
      end
    end
    $display("channels: yn=%b chg=%b", yn_ch, chg_ch);
  endtask

`ifdef G_NNOR_RT_MASK_EN
  task automatic test_mask_load;
    d_f4 = 4'b0000;
    mask_ld = 1'b1;
    mask_in = 4'b0000;
    tick();
    mask_ld = 1'b0;
    checks++;
    if ({yn_f4, chg_f4} !== 2'b00) begin
      errors++;
      $display("FAIL mask_load_edge: yn/chg=%b%b expected 00", yn_f4, chg_f4);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({yn_f4, chg_f4} !== ((i == 3) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL mask_new%0d: yn/chg=%b%b expected %b", i, yn_f4, chg_f4,
                 (i == 3) ? 2'b11 : 2'b00);
      end
    end
    mask_ld = 1'b1;
    mask_in = 4'b0111;
    tick();
    mask_ld = 1'b0;
    tick();
    tick();
    mask_ld = 1'b1;
    tick();
    mask_ld = 1'b0;
    checks++;
    if ({yn_f4, chg_f4} !== 2'b10) begin
      errors++;
      $display("FAIL mask_reload: yn/chg=%b%b expected 10", yn_f4, chg_f4);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({yn_f4, chg_f4} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL mask_clear%0d: yn/chg=%b%b expected %b", i, yn_f4, chg_f4,
                 (i == 3) ? 2'b01 : 2'b10);
      end
    end
    $display("mask_load: yn=%b chg=%b", yn_f4, chg_f4);
  endtask
`endif

  initial begin
    test_reset();
    test_filt1();
    test_glitch();
    test_ce_gaps();
    test_rst_mid();
    test_channels();
`ifdef G_NNOR_RT_MASK_EN
    test_mask_load();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
